// File: rtl/x_flashsm_mc_pkg.sv
// Shared types for the multi-channel LED flash generator: channel states, mode codes
// and the per-channel tick-counter width helper.
package x_flashsm_mc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlash = 2'd1,
    StHwait = 2'd2,
    StGap   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ModeOneshot = 2'd0,
    ModeRetrig  = 2'd1,
    ModeBlink   = 2'd2,
    ModeForce   = 2'd3
  } mode_e;

  // Counter must be able to hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned flash_ticks,
                                            input int unsigned gap_ticks);
    int unsigned longest;
    longest = (flash_ticks > gap_ticks) ? flash_ticks : gap_ticks;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/x_flashsm_mc_if.sv
// Per-channel trigger/hold/mode request bundle and the LED drive it produces.
interface x_flashsm_mc_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0]   trigger;
  logic [NCH-1:0]   hold;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0]   dout;

  modport master (output trigger, output hold, output mode, input dout);
  modport slave  (input trigger, input hold, input mode, output dout);
endinterface

// File: rtl/x_flashsm_mc_ch.sv
// One LED channel: input registers, edge detect, flash/hold/blink state machine,
// phase tick counter and registered LED drive.
module x_flashsm_mc_ch
  import x_flashsm_mc_pkg::*;
#(
  parameter int unsigned FLASH_TICKS = 12,
  parameter int unsigned GAP_TICKS   = 12,
  parameter bit          INVERT      = 1'b0
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  tick_i,
  input  logic  trigger_i,
  input  logic  hold_i,
  input  mode_e mode_i,
  output logic  dout_o
);

  localparam int unsigned CntW = cnt_width(FLASH_TICKS, GAP_TICKS);
  localparam logic [CntW-1:0] FlashLast = CntW'(FLASH_TICKS - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_TICKS - 1);

  logic            trig_ff_q, trig_ff_d;
  logic            trig_d_q, trig_d_d;
  logic            hold_ff_q, hold_ff_d;
  logic            armed_q, armed_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dout_q, dout_d;
  logic            trig_re;
  logic            done;

  assign trig_re = trig_ff_q & ~trig_d_q;
  assign done    = tick_i && (cnt_q == ((state_q == StGap) ? GapLast : FlashLast));

  always_comb begin
    trig_ff_d = trigger_i;
    // First clock after reset loads both edge-detect stages alike, so a trigger
    // held high across reset release does not count as an edge.
    trig_d_d  = armed_q ? trig_ff_q : trigger_i;
    hold_ff_d = hold_i | trigger_i;
    armed_d   = 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;

    case (state_q)
      StIdle: begin
        if (trig_re) begin
          state_d = StFlash;
          cnt_d   = '0;
        end
      end
      StFlash: begin
        if (trig_re && (mode_i == ModeRetrig)) begin
          cnt_d = '0;
        end else if (done) begin
          cnt_d = '0;
          if ((mode_i == ModeBlink) && hold_ff_q) begin
            state_d = StGap;
          end else if (hold_ff_q) begin
            state_d = StHwait;
          end else begin
            state_d = StIdle;
          end
        end else if (tick_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHwait: begin
        if (!hold_ff_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (done) begin
          cnt_d   = '0;
          state_d = hold_ff_q ? StFlash : StIdle;
        end else if (tick_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    dout_d = ((state_q == StFlash) || (state_q == StHwait) || (mode_i == ModeForce)) ^ INVERT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_ff_q <= 1'b0;
      trig_d_q  <= 1'b0;
      hold_ff_q <= 1'b0;
      armed_q   <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      dout_q    <= INVERT;
    end else begin
      trig_ff_q <= trig_ff_d;
      trig_d_q  <= trig_d_d;
      hold_ff_q <= hold_ff_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/x_flashsm_mc.sv
// Multi-channel LED flash/persistence generator: one shared prescaler feeding NCH
// independent flash channels.
module x_flashsm_mc
  import x_flashsm_mc_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned PRE_W       = 16,
  parameter int unsigned FLASH_TICKS = 12,
  parameter int unsigned GAP_TICKS   = 12,
  parameter bit          INVERT      = 1'b0
) (
  input logic             clock,
  input logic             reset,
  x_flashsm_mc_if.slave   led_if
);

  if (NCH < 1) begin : g_bad_nch
    $error("x_flashsm_mc: NCH must be >= 1");
  end
  if (PRE_W < 1) begin : g_bad_pre_w
    $error("x_flashsm_mc: PRE_W must be >= 1");
  end
  if (FLASH_TICKS < 1) begin : g_bad_flash
    $error("x_flashsm_mc: FLASH_TICKS must be >= 1");
  end
  if (GAP_TICKS < 1) begin : g_bad_gap
    $error("x_flashsm_mc: GAP_TICKS must be >= 1");
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [NCH-1:0]   dout;

  always_comb begin
    pre_d = pre_q + 1'b1;
  end

  // Tick fires on the all-ones count, once per 2**PRE_W clocks.
  assign tick = &pre_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    x_flashsm_mc_ch #(
      .FLASH_TICKS (FLASH_TICKS),
      .GAP_TICKS   (GAP_TICKS),
      .INVERT      (INVERT)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .tick_i    (tick),
      .trigger_i (led_if.trigger[i]),
      .hold_i    (led_if.hold[i]),
      .mode_i    (mode_e'(led_if.mode[2*i +: 2])),
      .dout_o    (dout[i])
    );
  end

  assign led_if.dout = dout;

endmodule

// File: tb/tb_x_flashsm_mc.sv
// Directed bench for x_flashsm_mc: NCH=2, P=4, FLASH_TICKS=3, GAP_TICKS=2, plus an
// INVERT=1 instance sharing clock and reset.
module tb_x_flashsm_mc;

  logic clock = 1'b0;
  logic reset = 1'b0;

  x_flashsm_mc_if #(.NCH(2)) bus ();
  x_flashsm_mc_if #(.NCH(2)) bus_inv ();

  x_flashsm_mc #(
    .NCH(2), .PRE_W(2), .FLASH_TICKS(3), .GAP_TICKS(2), .INVERT(1'b0)
  ) u_dut (
    .clock  (clock),
    .reset  (reset),
    .led_if (bus)
  );

  x_flashsm_mc #(
    .NCH(2), .PRE_W(2), .FLASH_TICKS(3), .GAP_TICKS(2), .INVERT(1'b1)
  ) u_dut_inv (
    .clock  (clock),
    .reset  (reset),
    .led_if (bus_inv)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Clock count since reset; equals the prescaler value mod 4 just after each edge.
  int ncyc = 0;
  always @(posedge clock or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  // Pulse-width monitor for ch0 and rise counter for ch1.
  int   on_w[$];
  int   off_w[$];
  int   run0   = 0;
  int   rises1 = 0;
  logic prev0  = 1'b0;
  logic prev1  = 1'b0;
  always @(negedge clock) begin
    prev0 <= bus.dout[0];
    prev1 <= bus.dout[1];
    if (bus.dout[1] && !prev1) rises1 <= rises1 + 1;
    if (bus.dout[0] !== prev0) begin
      if (prev0 === 1'b1) on_w.push_back(run0);
      else if (on_w.size() > 0) off_w.push_back(run0);
      run0 <= 1;
    end else begin
      run0 <= run0 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clr_mon();
    on_w.delete();
    off_w.delete();
  endtask

  task automatic wait_phase(input int k);
    for (int i = 0; i < 8 && (ncyc % 4) != k; i++) step(1);
    chk("phase_align", 32'(ncyc % 4), 32'(k));
  endtask

  int exp_w1[4] = '{10, 9, 12, 11};
  int exp_on4[4] = '{10, 12, 12, 12};
  int w;
  logic any_hi;
  logic all_hi;

  initial begin
    bus.trigger = '0; bus.hold = '0; bus.mode = '0;
    bus_inv.trigger = '0; bus_inv.hold = '0; bus_inv.mode = '0;

    // Reset acts without a clock edge.
    #1 reset = 1'b1;
    #1;
    chk("reset_dout", 32'(bus.dout), 32'd0);
    chk("reset_dout_inv", 32'(bus_inv.dout), 32'd3);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    step(1);

    // 1: ONESHOT, one-clock trigger at each prescaler phase.
    for (int k = 0; k < 4; k++) begin
      clr_mon();
      wait_phase(k);
      bus.trigger[0] = 1'b1;
      step(1);
      bus.trigger[0] = 1'b0;
      chk("t1_lat_e0", 32'(bus.dout[0]), 32'd0);
      step(1);
      chk("t1_lat_e1", 32'(bus.dout[0]), 32'd0);
      step(1);
      chk("t1_lat_e2", 32'(bus.dout[0]), 32'd1);
      step(16);
      chk("t1_npulse", 32'(on_w.size()), 32'd1);
      w = (on_w.size() > 0) ? on_w[0] : -1;
      chk("t1_width", 32'(w), 32'(exp_w1[k]));
    end
    chk("t1_ch1_quiet", 32'(rises1), 32'd0);

    // 2: hold keeps the LED on; it drops two clocks after hold is sampled low.
    clr_mon();
    bus.trigger[0] = 1'b1;
    bus.hold[0]    = 1'b1;
    step(1);
    bus.trigger[0] = 1'b0;
    step(2);
    all_hi = bus.dout[0];
    for (int i = 0; i < 37; i++) begin
      step(1);
      all_hi &= bus.dout[0];
    end
    chk("t2_continuous", 32'(all_hi), 32'd1);
    bus.hold[0] = 1'b0;
    step(1);
    chk("t2_e", 32'(bus.dout[0]), 32'd1);
    step(1);
    chk("t2_e1", 32'(bus.dout[0]), 32'd1);
    step(1);
    chk("t2_e2", 32'(bus.dout[0]), 32'd0);
    step(4);
    w = (on_w.size() > 0) ? on_w[0] : -1;
    chk("t2_width", 32'(w), 32'd40);

    // 3: second edge 6 clocks later; RETRIG restarts, ONESHOT ignores it.
    for (int m = 1; m >= 0; m--) begin
      clr_mon();
      bus.mode[1:0] = 2'(m);
      wait_phase(0);
      bus.trigger[0] = 1'b1;
      step(1);
      bus.trigger[0] = 1'b0;
      step(5);
      bus.trigger[0] = 1'b1;
      step(1);
      bus.trigger[0] = 1'b0;
      step(30);
      chk(m == 1 ? "t3_retrig_npulse" : "t3_oneshot_npulse", 32'(on_w.size()), 32'd1);
      w = (on_w.size() > 0) ? on_w[0] : -1;
      chk(m == 1 ? "t3_retrig_width" : "t3_oneshot_width", 32'(w), m == 1 ? 32'd18 : 32'd10);
      chk("t3_end_off", 32'(bus.dout[0]), 32'd0);
    end

    // 4: BLINK while held; last flash completes after hold drops.
    clr_mon();
    bus.mode[1:0] = 2'd2;
    wait_phase(0);
    bus.trigger[0] = 1'b1;
    bus.hold[0]    = 1'b1;
    step(1);
    bus.trigger[0] = 1'b0;
    step(59);
    bus.hold[0] = 1'b0;
    step(30);
    chk("t4_non", 32'(on_w.size()), 32'd4);
    chk("t4_noff", 32'(off_w.size()), 32'd3);
    for (int i = 0; i < 4; i++) begin
      w = (on_w.size() > i) ? on_w[i] : -1;
      chk("t4_on_w", 32'(w), 32'(exp_on4[i]));
    end
    for (int i = 0; i < 3; i++) begin
      w = (off_w.size() > i) ? off_w[i] : -1;
      chk("t4_off_w", 32'(w), 32'd8);
    end
    chk("t4_end_off", 32'(bus.dout[0]), 32'd0);
    bus.mode[1:0] = 2'd0;

    // 5: FORCE on ch1 without trigger, and the inverted build.
    chk("t1to4_ch1_quiet", 32'(rises1), 32'd0);
    bus.mode[3:2] = 2'd3;
    step(1);
    chk("t5_force_on", 32'(bus.dout[1]), 32'd1);
    chk("t5_force_ch0", 32'(bus.dout[0]), 32'd0);
    bus.mode[3:2] = 2'd0;
    step(1);
    chk("t5_force_off", 32'(bus.dout[1]), 32'd0);
    chk("t5_inv_idle", 32'(bus_inv.dout), 32'd3);
    bus_inv.trigger[0] = 1'b1;
    step(1);
    bus_inv.trigger[0] = 1'b0;
    step(2);
    chk("t5_inv_flash", 32'(bus_inv.dout), 32'd2);
    step(14);
    chk("t5_inv_after", 32'(bus_inv.dout), 32'd3);

    // 6: async reset mid-flash, then trigger held across release.
    bus.trigger[0] = 1'b1;
    step(1);
    bus.trigger[0] = 1'b0;
    step(3);
    chk("t6_flashing", 32'(bus.dout[0]), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_rst", 32'(bus.dout), 32'd0);
    bus.trigger[0] = 1'b1;
    step(2);
    #3 reset = 1'b0;
    any_hi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      any_hi |= bus.dout[0];
    end
    chk("t6_no_flash_held", 32'(any_hi), 32'd0);
    bus.trigger[0] = 1'b0;
    step(1);
    bus.trigger[0] = 1'b1;
    step(2);
    chk("t6_fresh_e1", 32'(bus.dout[0]), 32'd0);
    step(1);
    chk("t6_fresh_e2", 32'(bus.dout[0]), 32'd1);
    bus.trigger[0] = 1'b0;
    step(16);
    chk("t6_fresh_end", 32'(bus.dout[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
